spi_reg_bank: RTL and testbench

CPU-facing register bank sitting directly upstream of the SPI transaction controller. It holds the control word (`sal_c`) and transmit data word (`sal_d`) that the controller consumes. It absorbs the controller's write-back strobes (`WR2_c`/`IN2_c`, `WR2_d`/`IN2_d`): a transaction counter, self-clearing command bits, and received bytes queued in an RX FIFO. Software polls this FIFO or takes an interrupt.

---
 rtl/spi_reg_bank.sv | 137 +++++++++++++
 tb/tb_spi_reg_bank.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: CPU register bank (CTRL/TXDATA/RXDATA/STATUS) between software and the SPI
// transaction controller, with a byte-wide RX FIFO fed by the controller's data strobe.
module spi_reg_bank #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [1:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic [31:0] sal_c,
    output logic [31:0] sal_d,
    input  logic        WR2_c,
    input  logic [31:0] IN2_c,
    input  logic        WR2_d,
    input  logic [31:0] IN2_d,
    output logic        irq
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          r_start;
    logic          r_srst;
    logic          r_irqen;
    logic [7:0]    r_txn;
    logic [31:0]   r_txd;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic          r_wr2d_q;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push;
    logic          w_wr_ctrl;
    logic          w_wr_txd;
    logic          w_wr_stat;
    logic [31:0]   w_status;
    logic [31:0]   w_rd;
    logic          w_unused;

    assign sal_c      = {16'b0, r_txn, 5'b0, r_irqen, r_srst, r_start};
    assign sal_d      = r_txd;
    assign w_empty    = r_cnt == '0;
    assign w_full     = r_cnt == CW'(DEPTH);
    assign w_wr_ctrl  = cpu_we && cpu_addr == 2'd0;
    assign w_wr_txd   = cpu_we && cpu_addr == 2'd1;
    assign w_wr_stat  = cpu_we && cpu_addr == 2'd3;
    assign w_pop      = cpu_re && cpu_addr == 2'd2 && !w_empty;
    // The controller strobes WR2_d while resetting; SOFT_RST masks that edge.
    assign w_push_req = WR2_d && !r_wr2d_q && !r_srst;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_status   = {25'b0, r_ovf, w_full, w_empty, 4'b0} | 32'(r_cnt);
    assign w_unused   = &{1'b0, IN2_c[31:16], IN2_c[7:2], IN2_d[31:8]};

    always_comb begin
        w_rd = cpu_addr == 2'd0 ? sal_c :
               cpu_addr == 2'd1 ? r_txd :
               cpu_addr == 2'd2 ? (w_pop ? {1'b1, 23'b0, r_mem[r_rp]} : 32'b0) :
               w_status;
    end

    // CPU assignment comes last so it overrides the write-back on bits[1:0].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_start <= 1'b0;
            r_srst  <= 1'b0;
            r_irqen <= 1'b0;
            r_txn   <= 8'b0;
            r_txd   <= 32'b0;
        end else begin
            if (WR2_c) begin
                r_start <= IN2_c[0];
                r_srst  <= IN2_c[1];
                r_txn   <= IN2_c[15:8];
            end
            if (w_wr_ctrl) begin
                r_start <= cpu_wdata[0];
                r_srst  <= cpu_wdata[1];
                r_irqen <= cpu_wdata[2];
            end
            if (w_wr_txd)
                r_txd <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_wr2d_q <= 1'b0;
        end else begin
            r_wr2d_q <= WR2_d;
            if (r_srst) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else begin
                if (w_push)
                    r_wp <= r_wp + AW'(1);
                if (w_pop)
                    r_rp <= r_rp + AW'(1);
                if (w_push != w_pop)
                    r_cnt <= w_push ? r_cnt + CW'(1) : r_cnt - CW'(1);
                if (w_push_req && w_full && !w_pop)
                    r_ovf <= 1'b1;
                else if (w_wr_stat && cpu_wdata[6])
                    r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= IN2_d[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rdata <= 32'b0;
            irq       <= 1'b0;
        end else begin
            if (cpu_re)
                cpu_rdata <= w_rd;
            irq <= r_irqen && !w_empty;
        end
    end
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed stimulus against a queue-based model of the register bank,
// checked every cycle, plus literal expectations for the scenarios of interest.
module tb_spi_reg_bank;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic [1:0]  cpu_addr = 2'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic [31:0] cpu_rdata;
    logic [31:0] sal_c;
    logic [31:0] sal_d;
    logic        WR2_c = 1'b0;
    logic [31:0] IN2_c = 32'd0;
    logic        WR2_d = 1'b0;
    logic [31:0] IN2_d = 32'd0;
    logic        irq;

    always #5 clk = ~clk;

    spi_reg_bank #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .sal_c(sal_c), .sal_d(sal_d),
        .WR2_c(WR2_c), .IN2_c(IN2_c), .WR2_d(WR2_d), .IN2_d(IN2_d), .irq(irq)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    logic [7:0]  q[$];
    logic        m_start, m_srst, m_irqen, m_ovf, m_prev, m_irq;
    logic [7:0]  m_txn;
    logic [31:0] m_txd, m_rd;
    logic        m_pop, m_pushr;

    function automatic logic [31:0] m_ctrl();
        return {16'b0, m_txn, 5'b0, m_irqen, m_srst, m_start};
    endfunction

    function automatic logic [31:0] m_status();
        int sz = q.size();
        return 32'(sz) | (sz == 0 ? 32'h10 : 32'h0) | (sz == DEPTH ? 32'h20 : 32'h0)
               | (m_ovf ? 32'h40 : 32'h0);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            {m_start, m_srst, m_irqen, m_ovf, m_prev, m_irq} = '0;
            m_txn = '0;
            m_txd = '0;
            m_rd  = '0;
        end else begin
            m_pop   = cpu_re && cpu_addr == 2'd2 && q.size() != 0;
            m_pushr = WR2_d && !m_prev && !m_srst;
            if (cpu_re)
                m_rd = cpu_addr == 2'd0 ? m_ctrl() :
                       cpu_addr == 2'd1 ? m_txd :
                       cpu_addr == 2'd2 ? (m_pop ? {1'b1, 23'b0, q[0]} : 32'h0) :
                       m_status();
            m_irq = m_irqen && q.size() != 0;
            if (m_srst) begin
                q.delete();
                m_ovf = 1'b0;
            end else begin
                if (cpu_we && cpu_addr == 2'd3 && cpu_wdata[6])
                    m_ovf = 1'b0;
                if (m_pop)
                    void'(q.pop_front());
                if (m_pushr) begin
                    if (q.size() < DEPTH)
                        q.push_back(IN2_d[7:0]);
                    else
                        m_ovf = 1'b1;
                end
            end
            if (WR2_c) begin
                m_start = IN2_c[0];
                m_srst  = IN2_c[1];
                m_txn   = IN2_c[15:8];
            end
            if (cpu_we && cpu_addr == 2'd0) begin
                m_start = cpu_wdata[0];
                m_srst  = cpu_wdata[1];
                m_irqen = cpu_wdata[2];
            end
            if (cpu_we && cpu_addr == 2'd1)
                m_txd = cpu_wdata;
            m_prev = WR2_d;
        end
    end

    always @(negedge clk) begin
        chk("sal_c", sal_c, m_ctrl());
        chk("sal_d", sal_d, m_txd);
        chk("cpu_rdata", cpu_rdata, m_rd);
        chk("irq", 32'(irq), 32'(m_irq));
    end

    task automatic drv(logic we, logic re, logic [1:0] a, logic [31:0] wd,
                       logic wc, logic [31:0] ic, logic wd2, logic [7:0] id);
        @(negedge clk);
        cpu_we    = we;
        cpu_re    = re;
        cpu_addr  = a;
        cpu_wdata = wd;
        WR2_c     = wc;
        IN2_c     = ic;
        WR2_d     = wd2;
        IN2_d     = {24'h0, id};
    endtask

    task automatic idle();
        drv(0, 0, 2'd0, 32'h0, 0, 32'h0, 0, 8'h0);
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        drv(1, 0, a, d, 0, 32'h0, 0, 8'h0);
    endtask

    task automatic push(logic [7:0] b);
        drv(0, 0, 2'd0, 32'h0, 0, 32'h0, 1, b);
        drv(0, 0, 2'd0, 32'h0, 0, 32'h0, 0, b);
    endtask

    task automatic rdchk(logic [1:0] a, logic [31:0] lit, string name);
        drv(0, 1, a, 32'h0, 0, 32'h0, 0, 8'h0);
        idle();
        chk(name, cpu_rdata, lit);
        chk({name, "_model"}, m_rd, lit);
    endtask

    initial begin
        logic [31:0] r;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            r = $urandom;
            cpu_we    = r[0];
            cpu_re    = r[1];
            cpu_addr  = r[3:2];
            cpu_wdata = $urandom;
            WR2_c     = r[4];
            IN2_c     = $urandom;
            WR2_d     = r[5];
            IN2_d     = $urandom;
        end
        idle();
        chk("rst_sal_c", sal_c, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst = 1'b1;
        rdchk(2'd3, 32'h10, "status_after_reset");

        wr(2'd0, 32'h1);
        idle();
        chk("start_set", sal_c, 32'h1);
        drv(0, 0, 2'd0, 32'h0, 1, 32'h0000_0300, 0, 8'h0);
        idle();
        chk("start_cleared", sal_c, 32'h0000_0300);

        repeat (3) drv(0, 0, 2'd0, 32'h0, 0, 32'h0, 1, 8'hCC);
        idle();
        rdchk(2'd3, 32'h01, "edge_count");
        rdchk(2'd2, 32'h8000_00CC, "edge_byte");
        rdchk(2'd2, 32'h0, "empty_read");

        for (int i = 1; i <= 9; i++) push(8'(i));
        rdchk(2'd3, 32'h68, "ovf_status");
        for (int i = 1; i <= 8; i++) rdchk(2'd2, 32'h8000_0000 | 32'(i), "ovf_drain");
        rdchk(2'd3, 32'h50, "ovf_sticky");
        wr(2'd3, 32'h40);
        rdchk(2'd3, 32'h10, "ovf_cleared");

        wr(2'd1, 32'hDEAD_BEEF);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        rdchk(2'd3, 32'h03, "srst_pre");
        wr(2'd0, 32'h2);
        drv(0, 0, 2'd0, 32'h0, 1, 32'h0, 1, 8'h55);
        idle();
        rdchk(2'd3, 32'h10, "srst_flush");
        chk("srst_ctrl", sal_c, 32'h0);
        chk("srst_txd", sal_d, 32'hDEAD_BEEF);

        wr(2'd0, 32'h4);
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        idle();
        idle();
        chk("full_irq", 32'(irq), 32'h1);
        rdchk(2'd3, 32'h28, "full_status");
        drv(0, 1, 2'd2, 32'h0, 0, 32'h0, 1, 8'h18);
        idle();
        chk("pushpop_oldest", cpu_rdata, 32'h8000_0010);
        rdchk(2'd3, 32'h28, "pushpop_count");
        chk("pushpop_irq", 32'(irq), 32'h1);
        for (int i = 1; i < 8; i++) rdchk(2'd2, 32'h8000_0010 + 32'(i), "drain");
        drv(0, 1, 2'd2, 32'h0, 0, 32'h0, 0, 8'h0);
        idle();
        chk("drain_tail", cpu_rdata, 32'h8000_0018);
        chk("irq_hold", 32'(irq), 32'h1);
        idle();
        chk("irq_drop", 32'(irq), 32'h0);
        rdchk(2'd3, 32'h10, "final_status");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
